mash_ecn: RTL and testbench



---
 rtl/ddsm_pkg.sv | 15 +
 rtl/mash_ecn_if.sv | 27 ++
 rtl/mash_ecn_diff.sv | 23 ++
 rtl/mash_ecn.sv | 101 ++++++++++
 tb/tb_mash_ecn.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/ddsm_pkg.sv
// Shared definitions for the MASH 1-1-1 delta-sigma datapath (accumulator chain and ECN).
// Y range -3..+4 fits a 4-bit signed word without saturation.
package ddsm_pkg;

    localparam int Y_W   = 4;
    localparam int Y_MIN = -3;
    localparam int Y_MAX = 4;

    typedef struct packed {
        logic c1;
        logic c2;
        logic c3;
    } carry_t;

endpackage

// File: rtl/mash_ecn_if.sv
// Sample-side bundle between the MASH accumulator chain and the ECN/divider word output.
// No backpressure: the source strobes i_en, the ECN answers with a one-cycle o_vld.
interface mash_ecn_if #(
    parameter int N_W = 8
);
    import ddsm_pkg::*;

    logic                  i_en;
    logic                  i_c1;
    logic                  i_c2;
    logic                  i_c3;
    logic [N_W-1:0]        i_nint;
    logic signed [Y_W-1:0] o_y;
    logic [N_W-1:0]        o_div;
    logic                  o_vld;

    modport master (
        output i_en, i_c1, i_c2, i_c3, i_nint,
        input  o_y, o_div, o_vld
    );

    modport slave (
        input  i_en, i_c1, i_c2, i_c3, i_nint,
        output o_y, o_div, o_vld
    );

endinterface

// File: rtl/mash_ecn_diff.sv
// Enable-gated first difference of a 1-bit stream: o_d = a - a_prev (2-bit signed, -1..1).
// Combinational output; history advances only on i_en, no backpressure.
module mash_ecn_diff (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_a,
    output logic signed [1:0] o_d
);

    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= 1'b0;
        end else if (i_en) begin
            r_prev <= i_a;
        end
    end

    assign o_d = $signed({1'b0, i_a}) - $signed({1'b0, r_prev});

endmodule

// File: rtl/mash_ecn.sv
// MASH 1-1-1 error-cancellation network: y = a1 + (1-z^-1)a2 + (1-z^-1)^2 a3, div = nint + y.
// Latency 1 cycle from i_en to o_vld; no backpressure, state holds while i_en is low.
module mash_ecn
    import ddsm_pkg::*;
#(
    parameter int N_W   = 8,
    parameter bit ALIGN = 1'b0
) (
    input logic       i_clk,
    input logic       i_rst_n,
    mash_ecn_if.slave s_if
);

    carry_t                w_c;
    carry_t                w_a;
    logic signed [1:0]     w_d2;
    logic signed [1:0]     w_d3;
    logic signed [1:0]     r_d3_prev;
    logic signed [2:0]     w_dd3;
    logic signed [Y_W-1:0] w_y;
    logic [N_W-1:0]        w_div;
    logic signed [Y_W-1:0] r_y;
    logic [N_W-1:0]        r_div;
    logic                  r_vld;

    assign w_c = {s_if.i_c1, s_if.i_c2, s_if.i_c3};

    // Pipelined MASH delivers c1 two samples early and c2 one sample early relative to c3.
    generate
        if (ALIGN) begin : g_align
            logic [1:0] r_c1_dly;
            logic       r_c2_dly;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_c1_dly <= 2'b00;
                    r_c2_dly <= 1'b0;
                end else if (s_if.i_en) begin
                    r_c1_dly <= {r_c1_dly[0], w_c.c1};
                    r_c2_dly <= w_c.c2;
                end
            end

            assign w_a = {r_c1_dly[1], r_c2_dly, w_c.c3};
        end else begin : g_direct
            assign w_a = w_c;
        end
    endgenerate

    mash_ecn_diff u_diff_c2 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (s_if.i_en),
        .i_a     (w_a.c2),
        .o_d     (w_d2)
    );

    mash_ecn_diff u_diff_c3 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (s_if.i_en),
        .i_a     (w_a.c3),
        .o_d     (w_d3)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_d3_prev <= 2'sb00;
        end else if (s_if.i_en) begin
            r_d3_prev <= w_d3;
        end
    end

    // Second difference of c3: (a3 - a3_prev) - (a3_prev - a3_prev2), range -2..2.
    assign w_dd3 = $signed({w_d3[1], w_d3}) - $signed({r_d3_prev[1], r_d3_prev});

    assign w_y = $signed({{(Y_W-1){1'b0}}, w_a.c1})
               + $signed({{(Y_W-2){w_d2[1]}}, w_d2})
               + $signed({{(Y_W-3){w_dd3[2]}}, w_dd3});

    assign w_div = s_if.i_nint + {{(N_W-Y_W){w_y[Y_W-1]}}, w_y};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_y   <= '0;
            r_div <= '0;
            r_vld <= 1'b0;
        end else begin
            r_vld <= s_if.i_en;
            if (s_if.i_en) begin
                r_y   <= w_y;
                r_div <= w_div;
            end
        end
    end

    assign s_if.o_y   = r_y;
    assign s_if.o_div = r_div;
    assign s_if.o_vld = r_vld;

endmodule

// File: tb/tb_mash_ecn.sv
// Drives one sample stream into an ALIGN=0 and an ALIGN=1 instance side by side;
// expected records are queued per instance when a sample is driven and popped each cycle.
module tb_mash_ecn;

    localparam int NO_G = 99;

    typedef struct {
        bit vld;
        int y;
        int div;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mash_ecn_if #(.N_W(8)) if0 ();
    mash_ecn_if #(.N_W(8)) if1 ();

    mash_ecn #(.N_W(8), .ALIGN(1'b0)) u_dut0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .s_if    (if0.slave)
    );

    mash_ecn #(.N_W(8), .ALIGN(1'b1)) u_dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .s_if    (if1.slave)
    );

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference state, index = ALIGN setting of the instance.
    bit m_c1a[2], m_c1b[2], m_c2h[2], m_a2p[2], m_a3p[2], m_a3pp[2];
    int m_y[2], m_div[2];

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_c1a[d] = 0; m_c1b[d] = 0; m_c2h[d] = 0;
            m_a2p[d] = 0; m_a3p[d] = 0; m_a3pp[d] = 0;
            m_y[d]   = 0; m_div[d] = 0;
        end
    endtask

    task automatic model_step(input int d, input bit en, input bit c1, input bit c2,
                              input bit c3, input int nint, input int gy, output exp_t e);
        int a1, a2, a3, y;
        if (!en) begin
            e.vld = 1'b0;
            e.y   = m_y[d];
            e.div = m_div[d];
            return;
        end
        a1 = (d == 1) ? int'(m_c1b[d]) : int'(c1);
        a2 = (d == 1) ? int'(m_c2h[d]) : int'(c2);
        a3 = int'(c3);
        y  = a1 + a2 - int'(m_a2p[d]) + a3 - 2 * int'(m_a3p[d]) + int'(m_a3pp[d]);
        if (gy != NO_G) y = gy;
        m_a3pp[d] = m_a3p[d];
        m_a3p[d]  = c3;
        m_a2p[d]  = a2[0];
        m_c1b[d]  = m_c1a[d];
        m_c1a[d]  = c1;
        m_c2h[d]  = c2;
        m_y[d]    = y;
        m_div[d]  = (nint + y) & 255;
        e.vld = 1'b1;
        e.y   = m_y[d];
        e.div = m_div[d];
    endtask

    task automatic set_in(input bit en, input bit c1, input bit c2, input bit c3,
                          input logic [7:0] nint);
        if0.i_en = en; if0.i_c1 = c1; if0.i_c2 = c2; if0.i_c3 = c3; if0.i_nint = nint;
        if1.i_en = en; if1.i_c1 = c1; if1.i_c2 = c2; if1.i_c3 = c3; if1.i_nint = nint;
    endtask

    task automatic step(input bit en, input bit c1, input bit c2, input bit c3,
                        input int nint, input int g0 = NO_G, input int g1 = NO_G);
        exp_t e;
        @(negedge clk);
        set_in(en, c1, c2, c3, 8'(nint));
        model_step(0, en, c1, c2, c3, nint, g0, e);
        q0.push_back(e);
        model_step(1, en, c1, c2, c3, nint, g1, e);
        q1.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        chk("drain_q", q0.size() + q1.size(), 0);
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        #1;
        chk("rst_y0",   int'($signed(if0.o_y)), 0);
        chk("rst_div0", int'(if0.o_div), 0);
        chk("rst_vld0", int'(if0.o_vld), 0);
        chk("rst_y1",   int'($signed(if1.o_y)), 0);
        chk("rst_div1", int'(if1.o_div), 0);
        chk("rst_vld1", int'(if1.o_vld), 0);
        q0.delete();
        q1.delete();
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin : mon0
        exp_t e;
        #2;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("a0_vld", int'(if0.o_vld), int'(e.vld));
            chk("a0_y",   int'($signed(if0.o_y)), e.y);
            chk("a0_div", int'(if0.o_div), e.div);
        end else begin
            chk("a0_spurious_vld", int'(if0.o_vld), 0);
        end
    end

    always @(posedge clk) begin : mon1
        exp_t e;
        #2;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("a1_vld", int'(if1.o_vld), int'(e.vld));
            chk("a1_y",   int'($signed(if1.o_y)), e.y);
            chk("a1_div", int'(if1.o_div), e.div);
        end else begin
            chk("a1_spurious_vld", int'(if1.o_vld), 0);
        end
    end

    initial begin
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        model_clear();
        do_reset();

        // All carries high: ALIGN=0 gives 3,0,1,1; ALIGN=1 gives 1,0,1,1.
        step(1, 1, 1, 1, 100, 3, 1);
        step(1, 1, 1, 1, 100, 0, 0);
        step(1, 1, 1, 1, 100, 1, 1);
        step(1, 1, 1, 1, 100, 1, 1);

        // c3 = 0,1,0 with nint=1: last divider word wraps to 255.
        do_reset();
        step(1, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 1, 1, 1);
        step(1, 0, 0, 0, 1, -2, -2);

        // Maximum +4 on the third sample for ALIGN=0.
        do_reset();
        step(1, 1, 0, 1, 10, 2, 1);
        step(1, 1, 0, 0, 10, -1, -2);
        step(1, 1, 1, 1, 10, 4, 3);

        // Idle cycles hold history, outputs and drop o_vld; nint ignored while idle.
        do_reset();
        step(1, 0, 0, 1, 20, 1, 1);
        step(0, 1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 255)));
        step(0, 1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 255)));
        step(1, 0, 0, 0, 20, -2, -2);

        // Single c1 pulse: appears on the third output only when aligned.
        do_reset();
        step(1, 1, 0, 0, 50, 1, 0);
        step(1, 0, 0, 0, 50, 0, 0);
        step(1, 0, 0, 0, 50, 0, 1);
        step(1, 0, 0, 0, 50, 0, 0);

        // Single c2 pulse: aligned instance shows +1 then -1 one sample later.
        do_reset();
        step(1, 0, 1, 0, 50, 1, 0);
        step(1, 0, 0, 0, 50, -1, 1);
        step(1, 0, 0, 0, 50, 0, -1);

        // Mid-stream reset clears c3 history: following c3=0 gives 0, not -2.
        step(1, 0, 0, 1, 50, 1, 1);
        do_reset();
        step(1, 0, 0, 0, 50, 0, 0);

        // Random stream with sparse strobes checked against the reference model.
        for (int i = 0; i < 300; i++) begin
            if (i == 150) do_reset();
            step(($urandom % 4) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, 255)));
        end

        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        @(posedge clk);
        #3;
        chk("final_drain", q0.size() + q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
